ctrl_conv_read: RTL and testbench

- Read-side controller for the 1-D convolution datapath.
- Consumes the X (input) and F (filter) memories once the write controllers have filled them.
- For each output index, sequences sliding-window addresses and drives MAC valid/clear. It then captures the MAC result and presents it on an AXI-stream-style master port (m_valid/m_ready).
- Pulses conv_done when all N-M+1 outputs have been accepted, so the write controllers can be re-armed.

---
 rtl/ctrl_conv_read_if.sv | 23 ++
 rtl/ctrl_conv_read.sv | 116 +++++++++++
 tb/tb_ctrl_conv_read.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_conv_read_if.sv
// ctrl_conv_read_if: memory-read, MAC-strobe and output-stream signals of the convolution read controller
interface ctrl_conv_read_if #(
  parameter int XAW = 4,
  parameter int FAW = 2,
  parameter int DW  = 16
);
  logic [XAW-1:0] x_addr;
  logic [FAW-1:0] f_addr;
  logic           mac_valid;
  logic           mac_clear;
  logic [DW-1:0]  mac_result;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_ready;
  modport master (
    output x_addr, f_addr, mac_valid, mac_clear, m_data, m_valid,
    input  mac_result, m_ready
  );
  modport slave (
    input  x_addr, f_addr, mac_valid, mac_clear, m_data, m_valid,
    output mac_result, m_ready
  );
endinterface

// File: rtl/ctrl_conv_read.sv
// ctrl_conv_read: sliding-window read sequencer for the 1-D convolution MAC; define CONV_RELU_EN to ReLU each captured result
module ctrl_conv_read #(
  parameter int N       = 16,
  parameter int M       = 4,
  parameter int XAW     = 4,
  parameter int FAW     = 2,
  parameter int DW      = 16,
  parameter int MAC_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic x_full,
  input  logic f_full,
  output logic busy,
  output logic conv_done,
  ctrl_conv_read_if.master bus
);
  localparam int CW = $clog2(MAC_LAT + 2);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [XAW-1:0] i_q, i_d, x_addr_q, x_addr_d;
  logic [FAW-1:0] j_q, j_d, f_addr_q, f_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mac_valid_q, mac_valid_d, mac_clear_q, mac_clear_d;
  logic m_valid_q, m_valid_d, busy_q, busy_d, done_q, done_d;
  logic [DW-1:0] m_data_q, m_data_d, cap;
  always_comb begin
`ifdef CONV_RELU_EN
    cap = bus.mac_result[DW-1] ? '0 : bus.mac_result;
`else
    cap = bus.mac_result;
`endif
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    case (state_q)
      IDLE: if (start && x_full && f_full) begin
        state_d = RUN;
        i_d     = '0;
        j_d     = '0;
      end
      RUN: if (j_q == FAW'(M - 1)) begin
        state_d = DRAIN;
        j_d     = '0;
        cnt_d   = CW'(MAC_LAT + 1);
      end else j_d = j_q + FAW'(1);
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = OUT;
          m_valid_d = 1'b1;
          m_data_d  = cap;
        end
      end
      OUT: if (bus.m_ready) begin
        m_valid_d = 1'b0;
        if (i_q == XAW'(N - M)) state_d = DONE;
        else begin
          state_d = RUN;
          i_d     = i_q + XAW'(1);
          j_d     = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // addresses are registered from next state so they sit on the bus during the issuing RUN cycle
    x_addr_d    = state_d == RUN ? XAW'({1'b0, i_d} + (XAW + 1)'(j_d)) : x_addr_q;
    f_addr_d    = state_d == RUN ? j_d : f_addr_q;
    mac_valid_d = state_q == RUN;
    mac_clear_d = state_q == RUN && j_q == '0;
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      x_addr_q    <= '0;
      f_addr_q    <= '0;
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      x_addr_q    <= x_addr_d;
      f_addr_q    <= f_addr_d;
      mac_valid_q <= mac_valid_d;
      mac_clear_q <= mac_clear_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign bus.x_addr    = x_addr_q;
  assign bus.f_addr    = f_addr_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_clear = mac_clear_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign busy          = busy_q;
  assign conv_done     = done_q;
endmodule

// File: tb/tb_ctrl_conv_read.sv
// tb_ctrl_conv_read: scoreboard bench with memory/MAC models and a window-sum reference model
module tb_ctrl_conv_read;
  localparam int N = 16, M = 4, XAW = 4, FAW = 2, DW = 16, MAC_LAT = 1;
  localparam int PER = M + 2 + MAC_LAT;
  logic clk = 0, reset = 1, start = 0, x_full = 0, f_full = 0;
  logic busy, conv_done;
  ctrl_conv_read_if #(.XAW(XAW), .FAW(FAW), .DW(DW)) bus();
  ctrl_conv_read #(.N(N), .M(M), .XAW(XAW), .FAW(FAW), .DW(DW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .x_full(x_full), .f_full(f_full),
    .busy(busy), .conv_done(conv_done), .bus(bus)
  );
  always #5 clk = ~clk;
  int xm [N];
  int fm [M];
  int rd_x, rd_f, acc;
  always @(posedge clk) begin
    rd_x <= xm[bus.x_addr];
    rd_f <= fm[bus.f_addr];
    if (bus.mac_valid) acc <= bus.mac_clear ? rd_x * rd_f : acc + rd_x * rd_f;
  end
  assign bus.mac_result = acc[DW-1:0];
  int compared = 0, mismatched = 0;
  int exp_q[$], addr_q[$];
  int mode = 0, acc_cnt = 0, hold = 0, stall = 0, done_cnt = 0, cyc = 0, last_hs = 0;
  logic prev_valid = 0, prev_hs = 0;
  logic [DW-1:0] prev_data = '0;
  logic [XAW-1:0] px = '0;
  logic [FAW-1:0] pf = '0;
  task automatic check(string name, int act, int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void load_expect();
    for (int i = 0; i <= N - M; i++) begin
      int s = 0;
      for (int k = 0; k < M; k++) begin
        s += xm[i + k] * fm[k];
        addr_q.push_back(((i + k) << 8) | (k << 1) | int'(k == 0));
      end
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      exp_q.push_back(s & ((1 << DW) - 1));
    end
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.mac_clear && !bus.mac_valid) check("stray_clear", 1, 0);
      if (bus.mac_valid) begin
        if (addr_q.size() == 0) check("extra_mac_valid", 1, 0);
        else check("mac_addr", (int'(px) << 8) | (int'(pf) << 1) | int'(bus.mac_clear), addr_q.pop_front());
      end
      if (bus.m_valid && prev_valid && !prev_hs) check("hold_stable", bus.m_data, prev_data);
      if (bus.m_valid && !bus.m_ready) hold++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else check($sformatf("out%0d", acc_cnt), bus.m_data, exp_q.pop_front());
        if (mode == 0 && acc_cnt > 0) check("period", cyc - last_hs, PER);
        last_hs = cyc;
        acc_cnt++;
      end
      if (conv_done) begin
        check("done_all_out", exp_q.size() + addr_q.size(), 0);
        check("done_timing", cyc - last_hs, 1);
        done_cnt++;
      end
    end
    prev_valid = bus.m_valid;
    prev_hs    = bus.m_valid && bus.m_ready;
    prev_data  = bus.m_data;
    px         = bus.x_addr;
    pf         = bus.f_addr;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (mode == 1) bus.m_ready = 1'($urandom_range(0, 1));
    else if (mode == 2 && acc_cnt == 3 && stall < 5) begin
      bus.m_ready = 1'b0;
      if (bus.m_valid) stall++;
    end else bus.m_ready = 1'b1;
  end
  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done();
    int t = 0;
    while (!conv_done && t < 3000) begin
      cycles(1);
      t++;
    end
    if (t >= 3000) check("done_timeout", 1, 0);
  endtask
  task automatic do_run(int md);
    mode = md; acc_cnt = 0; hold = 0; stall = 0;
    load_expect();
    x_full = 1; f_full = 1; start = 1;
    cycles(1);
    start = 0;
    if (md == 1) x_full = 0;
    if (md == 2) begin
      int t = 0;
      while (hold == 0 && t < 500) begin
        cycles(1);
        t++;
      end
      start = 1;
      cycles(1);
      start = 0;
    end
    wait_done();
    cycles(1);
    check("busy_after_done", busy, 0);
    check("outputs_per_run", acc_cnt, N - M + 1);
  endtask
  task automatic basic_data();
    for (int i = 0; i < N; i++) xm[i] = i + 1;
    for (int k = 0; k < M; k++) fm[k] = 1;
  endtask
  initial begin
    int d;
    cycles(3);
    check("rst_busy", busy, 0);
    check("rst_done", conv_done, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_mac_valid", bus.mac_valid, 0);
    check("rst_mac_clear", bus.mac_clear, 0);
    check("rst_x_addr", bus.x_addr, 0);
    check("rst_f_addr", bus.f_addr, 0);
    check("rst_m_data", bus.m_data, 0);
    reset = 0;
    cycles(2);
    x_full = 1; f_full = 0; start = 1;
    cycles(1);
    start = 0;
    cycles(5);
    check("gate_busy", busy, 0);
    check("gate_done", done_cnt, 0);
    basic_data();
    do_run(0);
    check("basic_done_cnt", done_cnt, 1);
    do_run(2);
    check("bp_hold", hold, 5);
    check("bp_done_cnt", done_cnt, 2);
    repeat (3) begin
      for (int i = 0; i < N; i++) xm[i] = int'($urandom_range(0, 200)) - 100;
      for (int k = 0; k < M; k++) fm[k] = int'($urandom_range(0, 20)) - 10;
      do_run(1);
    end
    basic_data();
    mode = 0; acc_cnt = 0;
    load_expect();
    x_full = 1; f_full = 1; start = 1;
    cycles(1);
    start = 0;
    d = 0;
    while (acc_cnt < 6 && d < 500) begin
      cycles(1);
      d++;
    end
    cycles(1);
    d = done_cnt;
    reset = 1;
    exp_q.delete();
    addr_q.delete();
    cycles(1);
    check("abort_busy", busy, 0);
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_mac_valid", bus.mac_valid, 0);
    check("abort_x_addr", bus.x_addr, 0);
    check("abort_f_addr", bus.f_addr, 0);
    reset = 0;
    cycles(4);
    check("abort_no_done", done_cnt, d);
    do_run(0);
    for (int i = 0; i < N; i++) xm[i] = i + 1;
    fm[0] = 1; fm[1] = -2; fm[2] = 0; fm[3] = 0;
    do_run(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
